// File: rtl/scig_cif_conv_accum.sv
// scig_cif_conv_accum: kernel-window accumulator for the LeNet-5 conv datapath.
// Sums TAPS signed 32-bit products onto a bias. It then requantizes with a
// round-half-up arithmetic right shift and saturates to an OUT_W-bit activation.
// The activation is presented on a valid/ready port with full backpressure.
// Optional feature macro: SCIG_CIF_RELU_EN (clamps negative activations to 0).
module scig_cif_conv_accum #(
  parameter int TAPS  = 25,
  parameter int ACC_W = 44,
  parameter int SHIFT = 8,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic [31:0]      bias,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data
);

  localparam int CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TAPS - 1);

  // Half of one output LSB, added before the shift to round half up.
  localparam logic signed [ACC_W-1:0] RND =
    (SHIFT > 0) ? (ACC_W'(1) << ((SHIFT > 0) ? (SHIFT - 1) : 0)) : '0;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_ACC  = 2'd0,
    S_POST = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [CNT_W-1:0]        cnt;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] bias_ext;
  logic signed [ACC_W-1:0] rounded;
  logic signed [ACC_W-1:0] shifted;
  logic signed [OUT_W-1:0] sat;
  logic signed [OUT_W-1:0] post_val;
  logic                    xfer;
  logic                    handshake;

  assign in_ready  = ce & (state == S_ACC);
  assign xfer      = in_valid & in_ready;
  assign handshake = (state == S_OUT) & out_valid & out_ready;

  assign prod_ext = {{(ACC_W-32){in_data[31]}}, in_data};
  assign bias_ext = {{(ACC_W-32){bias[31]}}, bias};
  assign rounded  = acc + RND;
  assign shifted  = rounded >>> SHIFT;

  // Saturate the requantized sum to the activation range, then optionally ReLU.
  always_comb begin
    sat = shifted[OUT_W-1:0];
    if (shifted > SAT_MAX) begin
      sat = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (shifted < SAT_MIN) begin
      sat = {1'b1, {(OUT_W-1){1'b0}}};
    end
`ifdef SCIG_CIF_RELU_EN
    post_val = sat[OUT_W-1] ? '0 : sat;
`else
    post_val = sat;
`endif
  end

  // Next-state logic; ce and clr are applied at the state register.
  always_comb begin
    state_next = state;
    case (state)
      S_ACC:   if (xfer && (cnt == LAST)) state_next = S_POST;
      S_POST:  state_next = S_OUT;
      S_OUT:   if (handshake) state_next = S_ACC;
      default: state_next = S_ACC;
    endcase
  end

  // State register: clr aborts back to accumulation from any state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_ACC;
    end else if (ce) begin
      if (clr) state <= S_ACC;
      else     state <= state_next;
    end
  end

  // Tap counter and accumulator; the first tap of a window also loads the bias.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      acc <= '0;
    end else if (ce) begin
      if (clr) begin
        cnt <= '0;
        acc <= '0;
      end else if (xfer) begin
        if (cnt == '0) acc <= bias_ext + prod_ext;
        else           acc <= acc + prod_ext;
        if (cnt == LAST) cnt <= '0;
        else             cnt <= cnt + 1'b1;
      end
    end
  end

  // Output register: load the activation in S_POST and hold it until accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (ce) begin
      if (clr) begin
        out_valid <= 1'b0;
      end else if (state == S_POST) begin
        out_data  <= post_val;
        out_valid <= 1'b1;
      end else if (handshake) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_scig_cif_conv_accum.sv
// tb_scig_cif_conv_accum: scoreboard bench for scig_cif_conv_accum.
// The expected activation of each window is pushed to a queue when that window
// is driven. It is popped and compared when the DUT completes an output handshake.
module tb_scig_cif_conv_accum;

  localparam int TAPS  = 25;
  localparam int SHIFT = 8;
  localparam int OUT_W = 16;

  logic             clk;
  logic             reset;
  logic             ce;
  logic             clr;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic [31:0]      bias;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;

  int n_checks;
  int n_fails;
  logic [OUT_W-1:0] exp_q[$];

  scig_cif_conv_accum dut (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .bias      (bias),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  // 10-time-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, got running, required finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Counts every comparison and reports any mismatch
  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", tag, act, exp);
    end
  endtask

  // Reference model: bias plus n equal products, round-half-up shift, saturate
  function automatic logic [OUT_W-1:0] model(input logic [31:0] b, input logic [31:0] d, input int n);
    longint s;
    longint r;
    s = longint'($signed(b)) + longint'(n) * longint'($signed(d));
    r = (s + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
`ifdef SCIG_CIF_RELU_EN
    if (r < 0) r = 0;
`endif
    return r[OUT_W-1:0];
  endfunction

  // Scoreboard: compare on every cycle where an output handshake will complete
  always @(negedge clk) begin
    logic [OUT_W-1:0] e;
    if (!reset && ce && !clr && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_out", 1, 0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("out_data", out_data, e);
      end
    end
  end

  // Drive one product and wait (bounded) until it has been transferred
  task automatic sendTap(input logic [31:0] b, input logic [31:0] d);
    int waited;
    in_valid = 1'b1;
    in_data  = d;
    bias     = b;
    waited   = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!in_ready && waited < 200);
    if (!in_ready) checkOutput("tap_wait_timeout", 1, 0);
    @(posedge clk);
    #1;
  endtask

  // Drive n taps of a window; optionally drop ce for 3 cycles before tap ce_gap_at
  task automatic applyStimulus(input logic [31:0] b, input logic [31:0] d, input int n,
                               input int ce_gap_at, input bit expect_out);
    if (expect_out) exp_q.push_back(model(b, d, n));
    for (int i = 0; i < n; i++) begin
      if (i == ce_gap_at) begin
        ce       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        repeat (3) begin
          @(negedge clk);
          checkOutput("ce_hold_ready", in_ready, 0);
          @(posedge clk);
          #1;
        end
        ce = 1'b1;
      end
      sendTap(b, d);
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [OUT_W-1:0] held;
    int waited;
    n_checks  = 0;
    n_fails   = 0;
    reset     = 1'b1;
    ce        = 1'b1;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    bias      = '0;
    out_ready = 1'b1;
    idle(3);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Basic window with latency and single-cycle valid pulse
    applyStimulus(32'd0, 32'd256, TAPS, -1, 1'b1);
    checkOutput("lat_post_idle", out_valid, 0);
    checkOutput("post_not_ready", in_ready, 0);
    @(posedge clk);
    #1;
    checkOutput("lat_valid_rise", out_valid, 1);
    checkOutput("lat_data", out_data, 16'd25);
    @(posedge clk);
    #1;
    checkOutput("valid_one_cycle", out_valid, 0);
    checkOutput("ready_after_hs", in_ready, 1);

    // Rounding and saturation windows
    applyStimulus(32'd128, 32'd0, TAPS, -1, 1'b1);
    idle(3);
    applyStimulus(32'd127, 32'd0, TAPS, -1, 1'b1);
    idle(3);
    applyStimulus(32'd0, 32'h7FFF_FFFF, TAPS, -1, 1'b1);
    idle(3);
    applyStimulus(32'd0, 32'h8000_0000, TAPS, -1, 1'b1);
    idle(3);
    applyStimulus(32'd0, -32'sd256, TAPS, -1, 1'b1);
    idle(3);

    // Backpressure: output held, no transfers while stalled
    out_ready = 1'b0;
    applyStimulus(32'd0, 32'd256, TAPS, -1, 1'b1);
    @(posedge clk);
    #1;
    held     = model(32'd0, 32'd256, TAPS);
    in_valid = 1'b1;
    in_data  = 32'd7;
    repeat (5) begin
      @(negedge clk);
      checkOutput("bp_in_ready", in_ready, 0);
      checkOutput("bp_out_valid", out_valid, 1);
      checkOutput("bp_out_data", out_data, held);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    applyStimulus(32'd0, 32'd7, TAPS, -1, 1'b1);
    idle(3);

    // Asynchronous reset mid-window
    applyStimulus(32'd5000, 32'd256, 12, -1, 1'b0);
    #2;
    reset = 1'b1;
    #2;
    checkOutput("arst_out_valid", out_valid, 0);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("arst_in_ready", in_ready, 1);
    idle(2);
    checkOutput("arst_no_pulse", out_valid, 0);
    applyStimulus(32'd64, 32'd256, TAPS, -1, 1'b1);
    idle(3);

    // Synchronous clear mid-window, overriding a simultaneous transfer
    applyStimulus(32'd9000, 32'd256, 12, -1, 1'b0);
    clr      = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'd256;
    @(posedge clk);
    #1;
    clr      = 1'b0;
    in_valid = 1'b0;
    checkOutput("clr_in_ready", in_ready, 1);
    checkOutput("clr_out_valid", out_valid, 0);
    applyStimulus(32'd0, 32'd256, TAPS, -1, 1'b1);
    idle(3);

    // Clock-enable gap mid-window leaves the result unchanged
    applyStimulus(32'd0, 32'd256, TAPS, 12, 1'b1);
    idle(3);

    // Drain the scoreboard (bounded)
    waited = 0;
    while (exp_q.size() != 0 && waited < 100) begin
      @(posedge clk);
      waited++;
    end
    #1;
    checkOutput("queue_drain", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
